hwpe_stream_zero_source_chk: RTL and testbench

// - Head end of the zero (shadow) network; pairs with the zero sink at the tail.
// - Monitors a normal HWPE stream at its producer and drives a zero stream:
//   - same valid/strb as the normal stream;
//   - data forced to 0, so downstream datapath logic optimises away.
// - Sequential checker on the source end:
//   - zero network ready must equal normal ready (mismatch = fault);
//   - producer must obey the stream protocol: once valid is raised, valid and strb hold until handshake.
// - Faults go out as a per-cycle flag, a sticky flag and a saturating counter.

---
 rtl/hwpe_stream_zero_source_chk_if.sv | 34 +++
 rtl/hwpe_stream_zero_source_chk.sv | 101 ++++++++++
 tb/tb_hwpe_stream_zero_source_chk.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_zero_source_chk_if.sv
// ============================================================================
// Module      : hwpe_stream_intf_stream
// Description : HWPE valid/ready stream bundle with producer, consumer and observer views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport master (
    output valid, data, strb,
    input  ready
  );

  modport slave (
    input  valid, data, strb,
    output ready
  );

  // The observer never looks at the payload.
  modport monitor (
    input valid, ready, strb
  );
endinterface

`default_nettype wire

// File: rtl/hwpe_stream_zero_source_chk.sv
// ============================================================================
// Module      : hwpe_stream_zero_source_chk
// Description : Zero-network source: mirrors valid/strb with zeroed data and
//               checks ready equality and producer protocol stability.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_stream_zero_source_chk #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  input  wire logic                 clear_i,
  hwpe_stream_intf_stream.monitor   normal_i,
  hwpe_stream_intf_stream.master    zero_o,
  output logic                      fault_detected_o,
  output logic                      fault_sticky_o,
  output logic [CNT_WIDTH-1:0]      fault_cnt_o
);

  localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [STRB_WIDTH-1:0]  strb_q, strb_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic hs;
  logic f_rdy, f_drop, f_strb;
  logic fault;

  assign zero_o.valid = normal_i.valid;
  assign zero_o.strb  = normal_i.strb;
  assign zero_o.data  = '0;

  assign hs     = normal_i.valid & normal_i.ready;
  assign f_rdy  = zero_o.ready != normal_i.ready;
  assign f_drop = (state_q == PEND) & ~normal_i.valid;
  assign f_strb = (state_q == PEND) & normal_i.valid & (normal_i.strb != strb_q);
  assign fault  = rst_ni & ~clear_i & (f_rdy | f_drop | f_strb);

  always_comb begin
    state_d  = state_q;
    strb_d   = strb_q;
    sticky_d = sticky_q | fault;
    cnt_d    = cnt_q;
    if (fault && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (normal_i.valid && !normal_i.ready) begin
          state_d = PEND;
          strb_d  = normal_i.strb;
        end
      end
      PEND: begin
        // Handshake or withdrawn valid both end the pending beat.
        if (hs || !normal_i.valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d  = IDLE;
      strb_d   = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      strb_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      strb_q   <= strb_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fault_detected_o = fault;
  assign fault_sticky_o   = sticky_q;
  assign fault_cnt_o      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_zero_source_chk.sv
// ============================================================================
// Module      : tb_hwpe_stream_zero_source_chk
// Description : Directed-vector bench with expected-value queue and negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hwpe_stream_zero_source_chk;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       fault_a, sticky_a, fault_b, sticky_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_err    = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) normal ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) zero_a ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) zero_b ();

  hwpe_stream_zero_source_chk #(.DATA_WIDTH(32), .CNT_WIDTH(8)) u_dut_a (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear),
    .normal_i         (normal),
    .zero_o           (zero_a),
    .fault_detected_o (fault_a),
    .fault_sticky_o   (sticky_a),
    .fault_cnt_o      (cnt_a)
  );

  // Narrow counter instance sees identical stimulus to exercise saturation.
  hwpe_stream_zero_source_chk #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u_dut_b (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear),
    .normal_i         (normal),
    .zero_o           (zero_b),
    .fault_detected_o (fault_b),
    .fault_sticky_o   (sticky_b),
    .fault_cnt_o      (cnt_b)
  );

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       f;
    logic       st;
    logic [7:0] c;
    logic [1:0] c2;
    string      nm;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.nm, ".zvalid"},  {31'd0, zero_a.valid}, {31'd0, e.v});
      check({e.nm, ".zstrb"},   {28'd0, zero_a.strb},  {28'd0, e.s});
      check({e.nm, ".zdata"},   zero_a.data,           32'd0);
      check({e.nm, ".fault"},   {31'd0, fault_a},      {31'd0, e.f});
      check({e.nm, ".sticky"},  {31'd0, sticky_a},     {31'd0, e.st});
      check({e.nm, ".cnt"},     {24'd0, cnt_a},        {24'd0, e.c});
      check({e.nm, ".fault2"},  {31'd0, fault_b},      {31'd0, e.f});
      check({e.nm, ".sticky2"}, {31'd0, sticky_b},     {31'd0, e.st});
      check({e.nm, ".cnt2"},    {30'd0, cnt_b},        {30'd0, e.c2});
    end
  end

  // Drive one cycle of stimulus and queue the values expected at the following negedge.
  task automatic step(input logic rn, input logic cl, input logic v, input logic r,
                      input logic zr, input logic [3:0] s, input logic ef, input logic es,
                      input logic [7:0] ec, input logic [1:0] ec2, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rn;
    clear        = cl;
    normal.valid = v;
    normal.ready = r;
    normal.strb  = s;
    normal.data  = 32'hDEAD_BEE0 | {28'd0, s};
    zero_a.ready = zr;
    zero_b.ready = zr;
    e.v = v; e.s = s; e.f = ef; e.st = es; e.c = ec; e.c2 = ec2; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    rst_n        = 1'b0;
    clear        = 1'b0;
    normal.valid = 1'b0;
    normal.ready = 1'b0;
    normal.strb  = 4'h0;
    normal.data  = 32'h0;
    zero_a.ready = 1'b0;
    zero_b.ready = 1'b0;

    //    rn cl v  r  zr strb  ef es cnt   cnt2
    step(0, 0, 0, 0, 0, 4'h0, 0, 0, 8'd0, 2'd0, "rst0");
    step(0, 0, 1, 1, 0, 4'h7, 0, 0, 8'd0, 2'd0, "rst_mismatch");

    // clean traffic, 16 beats, protocol-compliant
    step(1, 0, 1, 1, 1, 4'h1, 0, 0, 8'd0, 2'd0, "clean1");
    step(1, 0, 1, 0, 0, 4'h2, 0, 0, 8'd0, 2'd0, "clean2");
    step(1, 0, 1, 0, 0, 4'h2, 0, 0, 8'd0, 2'd0, "clean3");
    step(1, 0, 1, 1, 1, 4'h2, 0, 0, 8'd0, 2'd0, "clean4");
    step(1, 0, 0, 1, 1, 4'h0, 0, 0, 8'd0, 2'd0, "clean5");
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 8'd0, 2'd0, "clean6");
    step(1, 0, 1, 1, 1, 4'h3, 0, 0, 8'd0, 2'd0, "clean7");
    step(1, 0, 1, 1, 1, 4'h4, 0, 0, 8'd0, 2'd0, "clean8");
    step(1, 0, 1, 0, 0, 4'h5, 0, 0, 8'd0, 2'd0, "clean9");
    step(1, 0, 1, 1, 1, 4'h5, 0, 0, 8'd0, 2'd0, "clean10");
    step(1, 0, 1, 1, 1, 4'h6, 0, 0, 8'd0, 2'd0, "clean11");
    step(1, 0, 0, 0, 0, 4'h9, 0, 0, 8'd0, 2'd0, "clean12");
    step(1, 0, 1, 0, 0, 4'h7, 0, 0, 8'd0, 2'd0, "clean13");
    step(1, 0, 1, 0, 0, 4'h7, 0, 0, 8'd0, 2'd0, "clean14");
    step(1, 0, 1, 0, 0, 4'h7, 0, 0, 8'd0, 2'd0, "clean15");
    step(1, 0, 1, 1, 1, 4'h7, 0, 0, 8'd0, 2'd0, "clean16");

    // ready mismatch for 3 cycles
    step(1, 0, 0, 1, 0, 4'h0, 1, 0, 8'd0, 2'd0, "rdy1");
    step(1, 0, 0, 1, 0, 4'h0, 1, 1, 8'd1, 2'd1, "rdy2");
    step(1, 0, 0, 1, 0, 4'h0, 1, 1, 8'd2, 2'd2, "rdy3");
    step(1, 0, 0, 0, 0, 4'h0, 0, 1, 8'd3, 2'd3, "rdy_after");
    step(1, 1, 0, 0, 0, 4'h0, 0, 1, 8'd3, 2'd3, "clr_a");

    // valid dropped while stalled
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 8'd0, 2'd0, "drop0");
    step(1, 0, 1, 0, 0, 4'hF, 0, 0, 8'd0, 2'd0, "drop1");
    step(1, 0, 0, 0, 0, 4'h0, 1, 0, 8'd0, 2'd0, "drop2");
    step(1, 0, 1, 0, 0, 4'h3, 0, 1, 8'd1, 2'd1, "drop_idle");
    step(1, 0, 1, 1, 1, 4'h3, 0, 1, 8'd1, 2'd1, "drop_hs");
    step(1, 1, 0, 0, 0, 4'h0, 0, 1, 8'd1, 2'd1, "clr_b");

    // strb changed while stalled
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 8'd0, 2'd0, "strb0");
    step(1, 0, 1, 0, 0, 4'hF, 0, 0, 8'd0, 2'd0, "strb1");
    step(1, 0, 1, 0, 0, 4'h3, 1, 0, 8'd0, 2'd0, "strb_chg");
    step(1, 0, 1, 1, 1, 4'hF, 0, 1, 8'd1, 2'd1, "strb_hs");
    step(1, 0, 0, 0, 0, 4'h0, 0, 1, 8'd1, 2'd1, "strb_after");
    step(1, 1, 0, 0, 0, 4'h0, 0, 1, 8'd1, 2'd1, "clr_c");

    // saturation of the 2-bit counter, then clear in a faulty cycle
    step(1, 0, 0, 1, 0, 4'h0, 1, 0, 8'd0, 2'd0, "sat1");
    step(1, 0, 0, 1, 0, 4'h0, 1, 1, 8'd1, 2'd1, "sat2");
    step(1, 0, 0, 1, 0, 4'h0, 1, 1, 8'd2, 2'd2, "sat3");
    step(1, 0, 0, 1, 0, 4'h0, 1, 1, 8'd3, 2'd3, "sat4");
    step(1, 0, 0, 1, 0, 4'h0, 1, 1, 8'd4, 2'd3, "sat5");
    step(1, 0, 0, 1, 0, 4'h0, 1, 1, 8'd5, 2'd3, "sat6");
    step(1, 0, 0, 0, 0, 4'h0, 0, 1, 8'd6, 2'd3, "sat_hold");
    step(1, 1, 0, 1, 0, 4'h0, 0, 1, 8'd6, 2'd3, "clr_fault");
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 8'd0, 2'd0, "clr_done");

    // several fault terms in one cycle count once
    step(1, 0, 1, 0, 0, 4'h1, 0, 0, 8'd0, 2'd0, "multi1");
    step(1, 0, 0, 1, 0, 4'h0, 1, 0, 8'd0, 2'd0, "multi2");
    step(1, 0, 0, 0, 0, 4'h0, 0, 1, 8'd1, 2'd1, "multi3");

    // reset while a beat is pending
    step(1, 0, 1, 0, 0, 4'hA, 0, 1, 8'd1, 2'd1, "rpend1");
    step(0, 0, 1, 0, 0, 4'hA, 0, 1, 8'd1, 2'd1, "rpend_rst");
    step(1, 0, 1, 0, 0, 4'h5, 0, 0, 8'd0, 2'd0, "rpend_new");
    step(1, 0, 1, 1, 1, 4'h5, 0, 0, 8'd0, 2'd0, "rpend_hs");
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 8'd0, 2'd0, "rpend_end");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
